// File: rtl/poly_stream_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poly_stream_buffer_pkg
// Description : Shared state type and bit-reverse helper for the polynomial
//               stream buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package poly_stream_buffer_pkg;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } poly_buf_state_t;

  localparam int unsigned c_ADDR_MAX = 16;

  // Reverses the low 'width' bits of value; bits at and above width read as 0.
  function automatic logic [c_ADDR_MAX-1:0] bitrev(input logic [c_ADDR_MAX-1:0] value,
                                                   input int unsigned width);
    logic [c_ADDR_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < c_ADDR_MAX; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_stream_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : poly_stream_buffer_if
// Description : Input and output coefficient stream handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
interface poly_stream_buffer_if #(
  parameter int COEF_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [COEF_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [COEF_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface
`default_nettype wire

// File: rtl/poly_stream_buffer_skid.sv
`default_nettype none
// ============================================================================
// Module      : poly_buf_skid
// Description : 2-entry FIFO of {data, last} that absorbs RAM read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_buf_skid #(
  parameter int WIDTH = 32
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             push_last,
  input  wire logic             pop,
  output logic      [1:0]       occ,
  output logic      [WIDTH-1:0] head_data,
  output logic                  head_last
);

  logic [WIDTH-1:0] r_data0, r_data1;
  logic             r_last0, r_last1;
  logic [1:0]       r_occ;
  logic             w_pop;

  assign w_pop     = pop && (r_occ != 2'd0);
  assign occ       = r_occ;
  assign head_data = r_data0;
  assign head_last = r_last0 && (r_occ != 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_occ   <= 2'd0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      case ({push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_data0 <= push_data;
            r_last0 <= push_last;
          end else begin
            r_data1 <= push_data;
            r_last1 <= push_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; a full buffer shifts while refilling the tail.
          if (r_occ == 2'd1) begin
            r_data0 <= push_data;
            r_last0 <= push_last;
          end else begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= push_data;
            r_last1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/poly_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : poly_stream_buffer
// Description : Loads one polynomial into the coefficient RAM, then streams it
//               out. Define POLY_BUF_BITREV_EN for bit-reversed read order.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_stream_buffer
  import poly_stream_buffer_pkg::*;
#(
  parameter int COEF_WIDTH = 32,
  parameter int N          = 256
) (
  input  wire logic                    clock,
  input  wire logic                    reset,
  poly_stream_buffer_if.slave          strm,
  output logic                         done,
  output logic                         busy,
  output logic                         ram_enable,
  output logic                         ram_write_en,
  output logic                         ram_reset,
  output logic [$clog2(N)-1:0]         ram_address,
  output logic [COEF_WIDTH-1:0]        ram_data_in,
  input  wire logic [COEF_WIDTH-1:0]   ram_data_out
);

  localparam int AW = $clog2(N);
  localparam logic [AW:0]   c_N      = (AW+1)'(N);
  localparam logic [AW:0]   c_RD_END = (AW+1)'(N - 1);
  localparam logic [AW-1:0] c_WR_END = AW'(N - 1);

  poly_buf_state_t r_state;
  logic [AW-1:0]   r_wr_cnt;
  logic [AW:0]     r_rd_cnt;
  logic            r_inflight;
  logic            r_inflight_last;

  logic [1:0]      w_occ;
  logic [2:0]      w_pending;
  logic            w_write;
  logic            w_pop;
  logic            w_issue;
  logic [AW-1:0]   w_rd_addr;

  assign strm.s_ready = (r_state == LOAD) && !reset;
  assign w_write      = strm.s_ready && strm.s_valid;
  assign w_pop        = strm.m_valid && strm.m_ready;
  assign w_pending    = {1'b0, w_occ} + {2'b00, r_inflight};
  // Counting the pop in flight keeps the buffer from ever holding more than 2.
  assign w_issue      = (r_state == DRAIN) && !reset && (r_rd_cnt < c_N) &&
                        (w_pending < (3'd2 + {2'b00, w_pop}));
  assign done         = w_pop && strm.m_last;
  assign busy         = (r_state == DRAIN);
  assign ram_reset    = reset;
  assign strm.m_valid = (w_occ != 2'd0);

`ifdef POLY_BUF_BITREV_EN
  assign w_rd_addr = AW'(bitrev(c_ADDR_MAX'(r_rd_cnt[AW-1:0]), AW));
`else
  assign w_rd_addr = r_rd_cnt[AW-1:0];
`endif

  always_comb begin
    ram_enable   = 1'b0;
    ram_write_en = 1'b0;
    ram_address  = '0;
    ram_data_in  = '0;
    if (w_write) begin
      ram_enable   = 1'b1;
      ram_write_en = 1'b1;
      ram_address  = r_wr_cnt;
      ram_data_in  = strm.s_data;
    end else if (w_issue) begin
      ram_enable  = 1'b1;
      ram_address = w_rd_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= LOAD;
      r_wr_cnt        <= '0;
      r_rd_cnt        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_rd_cnt == c_RD_END);
      case (r_state)
        LOAD: begin
          if (w_write) begin
            if (r_wr_cnt == c_WR_END) begin
              r_wr_cnt <= '0;
              r_state  <= DRAIN;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (done) begin
            r_state  <= LOAD;
            r_rd_cnt <= '0;
          end else if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  poly_buf_skid #(
    .WIDTH(COEF_WIDTH)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (r_inflight),
    .push_data (ram_data_out),
    .push_last (r_inflight_last),
    .pop       (strm.m_ready),
    .occ       (w_occ),
    .head_data (strm.m_data),
    .head_last (strm.m_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_poly_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_stream_buffer
// Description : Directed self-checking bench for poly_stream_buffer, N=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_stream_buffer;

  localparam int W  = 32;
  localparam int NN = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          done, busy, ram_enable, ram_write_en, ram_reset;
  logic [2:0]    ram_address;
  logic [W-1:0]  ram_data_in;
  logic [W-1:0]  ram_data_out;
  logic [W-1:0]  mem [NN];

  int checks = 0;
  int errors = 0;

  poly_stream_buffer_if #(.COEF_WIDTH(W)) strm ();

  poly_stream_buffer #(.COEF_WIDTH(W), .N(NN)) dut (
    .clock        (clock),
    .reset        (reset),
    .strm         (strm),
    .done         (done),
    .busy         (busy),
    .ram_enable   (ram_enable),
    .ram_write_en (ram_write_en),
    .ram_reset    (ram_reset),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clock = ~clock;

  // Single-port read-first RAM with one cycle of read latency.
  always_ff @(posedge clock) begin
    if (ram_reset) ram_data_out <= '0;
    else if (ram_enable) ram_data_out <= mem[ram_address];
    if (ram_enable && ram_write_en) mem[ram_address] <= ram_data_in;
  end

  function automatic logic [W-1:0] exp_val(input int base, input int k);
    int rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`ifdef POLY_BUF_BITREV_EN
    return W'(base + rev[k]);
`else
    if (rev[0] != 0) return '0;
    return W'(base + k);
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_poly(input int base);
    for (int i = 0; i < NN; i++) begin
      strm.s_valid = 1'b1;
      strm.s_data  = W'(base + i);
      tick();
    end
    strm.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; strm.s_valid = 1'b0; strm.s_data = '0; strm.m_ready = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    checks++; if (strm.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %0b exp 0", strm.s_ready); end
    checks++; if (strm.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %0b exp 0", strm.m_valid); end
    checks++; if (strm.m_data !== '0) begin errors++; $display("FAIL rst_m_data got %0h exp 0", strm.m_data); end
    checks++; if (strm.m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last got %0b exp 0", strm.m_last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %0b%0b exp 00", busy, done); end
    checks++; if (ram_enable !== 1'b0 || ram_write_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %0b%0b exp 00", ram_enable, ram_write_en); end
    checks++; if (ram_reset !== 1'b1) begin errors++; $display("FAIL rst_ram_reset got %0b exp 1", ram_reset); end
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (strm.s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_s_ready got %0b exp 1", strm.s_ready); end
    checks++; if (ram_enable !== 1'b0) begin errors++; $display("FAIL post_rst_ram_enable got %0b exp 0", ram_enable); end
    tick();
  endtask

  // Back-to-back load of 1..8, full-rate drain with s_valid held high throughout.
  task automatic test_stream();
    int k = 0;
    for (int i = 0; i < NN; i++) begin
      strm.s_valid = 1'b1;
      strm.s_data  = W'(1 + i);
      @(negedge clock);
      checks++; if (ram_write_en !== 1'b1 || ram_enable !== 1'b1) begin errors++; $display("FAIL load_we[%0d] got %0b%0b exp 11", i, ram_enable, ram_write_en); end
      checks++; if (ram_address !== 3'(i)) begin errors++; $display("FAIL load_addr[%0d] got %0d exp %0d", i, ram_address, i); end
      checks++; if (ram_data_in !== W'(1 + i)) begin errors++; $display("FAIL load_data[%0d] got %0h exp %0h", i, ram_data_in, 1 + i); end
      tick();
    end
    strm.s_data = W'(99);
    strm.m_ready = 1'b1;
    for (int c = 0; c < 16 && k < NN; c++) begin
      @(negedge clock);
      checks++; if (strm.s_ready !== 1'b0 || ram_write_en !== 1'b0) begin errors++; $display("FAIL drain_no_write c%0d got rdy=%0b we=%0b exp 0 0", c, strm.s_ready, ram_write_en); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy c%0d got %0b exp 1", c, busy); end
      checks++; if (strm.m_valid !== (c >= 2)) begin errors++; $display("FAIL drain_valid c%0d got %0b exp %0b", c, strm.m_valid, c >= 2); end
      if (strm.m_valid === 1'b1) begin
        checks++; if (strm.m_data !== exp_val(1, k)) begin errors++; $display("FAIL drain_data[%0d] got %0h exp %0h", k, strm.m_data, exp_val(1, k)); end
        checks++; if (strm.m_last !== (k == NN - 1) || done !== (k == NN - 1)) begin errors++; $display("FAIL drain_last_done[%0d] got %0b%0b exp %0b", k, strm.m_last, done, k == NN - 1); end
        k++;
      end
      tick();
    end
    checks++; if (k != NN) begin errors++; $display("FAIL drain_count got %0d exp %0d", k, NN); end
    @(negedge clock);
    checks++; if (strm.s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL after_done got rdy=%0b busy=%0b exp 1 0", strm.s_ready, busy); end
    checks++; if (ram_write_en !== 1'b1 || ram_address !== 3'd0) begin errors++; $display("FAIL after_done_write got we=%0b addr=%0d exp 1 0", ram_write_en, ram_address); end
    strm.s_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  // s_valid gaps during load, random m_ready during drain.
  task automatic test_backpressure();
    int wr = 0, k = 0, outstanding = 0;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data = '0;
    logic          iss, pop;
    for (int j = 0; j < 30 && wr < NN; j++) begin
      strm.s_valid = (j % 3) != 1;
      strm.s_data  = W'(21 + wr);
      @(negedge clock);
      checks++; if (ram_write_en !== strm.s_valid) begin errors++; $display("FAIL gap_we j%0d got %0b exp %0b", j, ram_write_en, strm.s_valid); end
      if (strm.s_valid) begin
        checks++; if (ram_address !== 3'(wr)) begin errors++; $display("FAIL gap_addr got %0d exp %0d", ram_address, wr); end
        wr++;
      end
      tick();
    end
    strm.s_valid = 1'b0;
    for (int c = 0; c < 100 && k < NN; c++) begin
      strm.m_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      iss = ram_enable && !ram_write_en;
      pop = strm.m_valid && strm.m_ready;
      if (prev_stall) begin
        checks++; if (strm.m_valid !== 1'b1 || strm.m_data !== prev_data) begin errors++; $display("FAIL bp_hold c%0d got v=%0b d=%0h exp 1 %0h", c, strm.m_valid, strm.m_data, prev_data); end
      end
      outstanding = outstanding + int'(iss) - int'(pop);
      checks++; if (outstanding > 2) begin errors++; $display("FAIL bp_outstanding c%0d got %0d exp <=2", c, outstanding); end
      if (pop) begin
        checks++; if (strm.m_data !== exp_val(21, k) || strm.m_last !== (k == NN - 1)) begin errors++; $display("FAIL bp_data[%0d] got %0h/%0b exp %0h/%0b", k, strm.m_data, strm.m_last, exp_val(21, k), k == NN - 1); end
        k++;
      end
      prev_stall = strm.m_valid && !strm.m_ready;
      prev_data  = strm.m_data;
      tick();
    end
    checks++; if (k != NN) begin errors++; $display("FAIL bp_count got %0d exp %0d", k, NN); end
    strm.m_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_drain();
    int pops = 0, k = 0;
    load_poly(1);
    strm.m_ready = 1'b1;
    for (int c = 0; c < 20 && pops < 3; c++) begin
      @(negedge clock);
      if (strm.m_valid && strm.m_ready) pops++;
      tick();
    end
    checks++; if (pops != 3) begin errors++; $display("FAIL mid_pops got %0d exp 3", pops); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (strm.s_ready !== 1'b0 || ram_enable !== 1'b0) begin errors++; $display("FAIL mid_rst_gate got rdy=%0b en=%0b exp 0 0", strm.s_ready, ram_enable); end
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (strm.m_valid !== 1'b0 || strm.m_data !== '0 || strm.m_last !== 1'b0) begin errors++; $display("FAIL mid_rst_out got v=%0b d=%0h l=%0b exp 0 0 0", strm.m_valid, strm.m_data, strm.m_last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || strm.s_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_state got busy=%0b done=%0b rdy=%0b exp 0 0 1", busy, done, strm.s_ready); end
    tick();
    load_poly(11);
    for (int c = 0; c < 20 && k < NN; c++) begin
      @(negedge clock);
      if (strm.m_valid) begin
        checks++; if (strm.m_data !== exp_val(11, k)) begin errors++; $display("FAIL reload_data[%0d] got %0h exp %0h", k, strm.m_data, exp_val(11, k)); end
        k++;
      end
      tick();
    end
    checks++; if (k != NN) begin errors++; $display("FAIL reload_count got %0d exp %0d", k, NN); end
  endtask

  initial begin
    strm.s_valid = 1'b0;
    strm.s_data  = '0;
    strm.m_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/poly_stream_buffer.md
# poly_stream_buffer

Load/drain controller that streams one polynomial (N coefficients) into the single-port, read-first, 1-cycle-latency coefficient RAM and then streams it back out in order or in bit-reversed order. Sits between the coefficient source (sampler/unpacker) and the NTT/arithmetic datapath. It owns every RAM port and hides the RAM read latency behind a 2-entry output buffer, sustaining 1 word/cycle under backpressure.

## Interface
- COEF_WIDTH, 32, coefficient width in bits
- N, 256, coefficients per polynomial; power of two, ≥ 4
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- s_valid  in  1  input coefficient valid
- s_ready  out  1  block accepts input; 1 only in LOAD and while reset is low
- s_data  in  COEF_WIDTH  input coefficient
- m_valid  out  1  output coefficient valid
- m_ready  in  1  downstream accepts output
- m_data  out  COEF_WIDTH  output coefficient
- m_last  out  1  marks the N-th output word
- done  out  1  one-cycle pulse when the drain completes
- busy  out  1  1 in DRAIN
- ram_enable  out  1  RAM enable
- ram_write_en  out  1  RAM write enable
- ram_reset  out  1  RAM output-register reset; equals reset
- ram_address  out  $clog2(N)  RAM address
- ram_data_in  out  COEF_WIDTH  RAM write data
- ram_data_out  in  COEF_WIDTH  RAM read data, valid 1 cycle after a read issue

## Operation
- States: LOAD (reset state), DRAIN.
- LOAD: s_ready=1. On each s_valid&&s_ready: ram_enable=1, ram_write_en=1, ram_address=wr_cnt, ram_data_in=s_data, wr_cnt++. The transfer with wr_cnt==N−1 moves the state to DRAIN and clears wr_cnt.
- DRAIN: read issue when rd_cnt<N and occ + inflight − (m_valid&&m_ready) < 2 (occ = buffer entries 0..2, inflight = read issued last cycle). Issue: ram_enable=1, ram_write_en=0, ram_address=rd_cnt (or bitrev, see Configuration), rd_cnt++.
- Returned data (inflight=1) is pushed into the buffer the following cycle, whatever m_ready is; the issue rule guarantees the buffer never overflows.
- m_valid = buffer non-empty; m_data = head entry; m_last = 1 on the head entry tagged as the N-th read.
- Exit: pop of the m_last word → state LOAD, rd_cnt=0, done=1 for that cycle. Input is accepted again from the next cycle.
- Outside issue/write cycles ram_enable=0, ram_write_en=0, ram_address=0, ram_data_in=0.
- Reset: state LOAD, wr_cnt=rd_cnt=0, buffer empty, inflight=0. Reset values: s_ready=0 while reset is high, m_valid=0, m_last=0, m_data=0, done=0, busy=0, ram_enable=0, ram_write_en=0. RAM contents are not cleared. Reset mid-LOAD or mid-DRAIN discards the partial polynomial.

## Timing
- Write latency: the word is in RAM at the edge that accepts it.
- Read latency: first m_valid 2 cycles after entering DRAIN (issue at D0, data at D1, buffered at D2).
- With m_ready held at 1: one word per cycle from D2; last word at D(N+1); done in the same cycle; LOAD at D(N+2).
- m_ready low: at most 2 issues are outstanding; m_data/m_valid hold stable until popped; no word is lost or duplicated.
- s_valid in DRAIN is ignored (s_ready=0).

## Configuration
- POLY_BUF_BITREV_EN defined: read address = bit-reverse of rd_cnt over $clog2(N) bits, so output is in bit-reversed order for the NTT. Write order is unchanged.
- Not defined: read address = rd_cnt (natural order).

## Structure
- Shared package: poly_buf_state_t enum {LOAD, DRAIN}; the bitrev function parameterised by address width.
- Sub-module poly_buf_skid: 2-entry FIFO {data, last} with push/pop/occ. It performs push and pop in the same cycle when occ=2.

## Test plan
- N=8, stream 1..8 with s_valid=1, m_ready=1 → 8 consecutive RAM writes to addr 0..7; outputs 1..8 on consecutive cycles from D2; m_last and done on word 8.
- Same with POLY_BUF_BITREV_EN → outputs 1,5,3,7,2,6,4,8.
- Random m_ready (50%) during drain → exactly 8 outputs in order; each m_data stable while m_valid&&!m_ready; no more than 2 outstanding reads.
- Random s_valid gaps in LOAD → writes only on handshake cycles; addresses contiguous 0..7.
- reset pulse after 3 output words → all outputs 0 the next cycle and state LOAD; a following load of 11..18 drains as 11..18.
- s_valid held high through DRAIN → no RAM write and s_ready=0 until the cycle after done.
